bcd_seq_converter: RTL and testbench

- Multi-cycle, sequential double-dabble binary-to-BCD converter with a valid/ready handshake on input and output.
- It owns a single shift/add-3 datapath and steps it one bit per clock under a small FSM, where the combinational converter is one unrolled array.
- Used in the digital clock where conversion latency is irrelevant and area matters, e.g. converting counter values for the 7-segment display path.
- Output width and digit ordering are identical to the combinational converter, so the two are interchangeable downstream.

---
 rtl/bcd_seq_converter.sv | 119 +++++++++++
 tb/tb_bcd_seq_converter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter
// Sequential double-dabble binary-to-BCD converter. A single add-3/shift
// datapath is stepped one input bit per clock by a three-state FSM
// (IDLE -> SHIFT -> DONE). The output width and digit ordering match the
// combinational converter, so either can sit in the same downstream path.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   bin is valid this cycle
//   in_ready   block can accept a new value (IDLE only)
//   bin[W-1:0] binary value, sampled only on the accept edge
//   out_valid  bcd holds a completed result (DONE only)
//   out_ready  consumer takes the result this cycle
//   bcd[BW-1:0] result {..., hundreds, tens, ones}, ones in bits [3:0]
//   busy       conversion in progress (SHIFT)
module bcd_seq_converter #(
  parameter  int W  = 8,
  localparam int BW = W + (W - 4) / 3 + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  bin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] bcd,
  output logic          busy
);

  localparam int ND = (BW + 3) / 4;
  localparam int DW = 4 * ND;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [DW+W-1:0] step;

  // Double-dabble correction: every digit above 4 gets +3 (mod 16) so that
  // the following left shift carries correctly into the next decade.
  function automatic logic [DW-1:0] add3_all(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    for (int i = 0; i < ND; i++) begin
      if (d[4*i +: 4] > 4'd4) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dig_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dig_q   <= dig_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dig_d   = dig_q;
    bcd_d   = bcd_q;
    // Correct first, then shift the whole {digits, shift register} left;
    // the shift register MSB lands in the LSB of digit 0.
    step    = {add3_all(dig_q), sr_q} << 1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = bin;
          dig_d   = '0;
          cnt_d   = CW'(W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        dig_d = step[DW+W-1:W];
        sr_d  = step[W-1:0];
        cnt_d = cnt_q - CW'(1);
        // Last iteration: capture the freshly shifted digits directly so the
        // result is available the same edge the counter reaches zero.
        if (cnt_q == CW'(1)) begin
          bcd_d   = step[W+BW-1:W];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes; in_ready never looks at out_ready.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
module tb_bcd_seq_converter;

  localparam int W   = 8;
  localparam int BW  = 10;
  localparam int W6  = 6;
  localparam int BW6 = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  bin;
  logic [BW-1:0] bcd;

  logic           in_valid6, in_ready6, out_valid6, out_ready6, busy6;
  logic [W6-1:0]  bin6;
  logic [BW6-1:0] bcd6;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .busy(busy)
  );

  bcd_seq_converter #(.W(W6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .bin(bin6),
    .out_valid(out_valid6), .out_ready(out_ready6), .bcd(bcd6), .busy(busy6)
  );

  // Decimal digits by plain division, ones in bits [3:0].
  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the W=8 instance: 0 = waiting for input,
  // 1 = converting (m_left edges to go), 2 = holding a result.
  int          m_st   = 0;
  int          m_left = 0;
  int          m_val  = 0;
  logic [23:0] m_bcd  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_st   <= 0;
      m_left <= 0;
      m_bcd  <= '0;
    end else begin
      case (m_st)
        0: if (in_valid) begin
             m_val  <= int'(bin);
             m_left <= W;
             m_st   <= 1;
           end
        1: begin
             m_left <= m_left - 1;
             if (m_left == 1) begin
               m_bcd <= to_bcd(m_val);
               m_st  <= 2;
             end
           end
        default: if (out_ready) m_st <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, sampled after the edge settles.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_st == 0});
      chk("busy", {31'd0, busy}, {31'd0, m_st == 1});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_st == 2});
      chk("bcd", 32'(bcd), 32'(m_bcd[BW-1:0]));
    end
  end

  task automatic wait_ov(output int k);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("wait_out_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k, got, next, cyc;
    logic [23:0] t;
    int exp_q[$];

    rst = 1'b1; in_valid = 1'b0; bin = '0; out_ready = 1'b1;
    in_valid6 = 1'b0; bin6 = '0; out_ready6 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Pin the model's decimal arithmetic.
    t = to_bcd(255); chk("model_255", 32'(t[9:0]), 32'h255);
    t = to_bcd(99);  chk("model_99", 32'(t[9:0]), 32'h099);
    t = to_bcd(59);  chk("model_59", 32'(t[6:0]), 32'h59);

    // 255 with out_ready high: 8-edge latency, then ready again.
    @(negedge clk); in_valid = 1'b1; bin = 8'd255;
    @(negedge clk); in_valid = 1'b0;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_ov(k);
    chk("t1_latency", 32'(k), 32'd8);
    chk("t1_bcd", 32'(bcd), 32'h255);
    @(negedge clk);
    chk("t1_ready_back", {31'd0, in_ready}, 32'd1);

    // 0 then 99 with in_valid held; bin changes during SHIFT must be ignored.
    in_valid = 1'b1; bin = 8'd0;
    @(negedge clk); bin = 8'd99;
    wait_ov(k);
    chk("t2_latency", 32'(k), 32'd8);
    chk("t2_bcd0", 32'(bcd), 32'h000);
    @(negedge clk);
    k = 1;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t2_period", 32'(k), 32'(W + 2));
    chk("t2_bcd99", 32'(bcd), 32'h099);
    in_valid = 1'b0;
    @(negedge clk);

    // 128 under 20 cycles of backpressure.
    out_ready = 1'b0; in_valid = 1'b1; bin = 8'd128;
    @(negedge clk); in_valid = 1'b0;
    wait_ov(k);
    repeat (20) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_bcd", 32'(bcd), 32'h128);
      chk("t3_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release", {31'd0, out_valid}, 32'd0);

    // Reset four edges into converting 200.
    in_valid = 1'b1; bin = 8'd200;
    @(negedge clk); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t4_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_rst_busy", {31'd0, busy}, 32'd0);
    chk("t4_rst_bcd", 32'(bcd), 32'd0);
    chk("t4_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("t4_no_stale_result", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1; bin = 8'd7;
    @(negedge clk); in_valid = 1'b0;
    wait_ov(k);
    chk("t4_bcd7", 32'(bcd), 32'h007);
    @(negedge clk);

    // W=6 instance: every input, 6-edge latency.
    for (int v = 0; v < 64; v++) begin
      k = 0;
      while (!in_ready6 && k < 40) begin
        @(negedge clk);
        k++;
      end
      in_valid6 = 1'b1; bin6 = 6'(v);
      @(negedge clk); in_valid6 = 1'b0;
      chk("w6_busy", {31'd0, busy6}, 32'd1);
      k = 0;
      while (!out_valid6 && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("w6_latency", 32'(k), 32'd6);
      t = to_bcd(v);
      chk("w6_bcd", 32'(bcd6), 32'(t[6:0]));
      if (v == 59) chk("w6_bcd59", 32'(bcd6), 32'h59);
    end

    // W=8 sweep with random input gaps and output stalls.
    got = 0; next = 0; cyc = 0;
    while (got < 256 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      in_valid  = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sweep_duplicate", 32'd1, 32'd0);
        end else begin
          t = to_bcd(exp_q.pop_front());
          chk("sweep_bcd", 32'(bcd), 32'(t[BW-1:0]));
        end
        got++;
      end
      if (in_ready && next < 256 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        bin = 8'(next);
        exp_q.push_back(next);
        next++;
      end
    end
    chk("sweep_count", 32'(got), 32'd256);
    chk("sweep_leftover", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
